// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the load/store stage: opcodes, memory funct3
// encodings and the LSU state machine encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_WB
  } lsu_state_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data extraction: selects the byte/halfword lane by the low
// address bits and sign- or zero-extends according to funct3.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store/writeback stage: issues data-memory requests, formats load data,
// and produces a single register-file write per accepted instruction.
module lsu_stage
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  lsu_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic             err_q;
  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [31:0]      addr_q;
  logic [31:0]      rs2_q;
  logic [31:0]      wb_q;
  logic [31:0]      fmt_data;

  logic accept;
  logic in_is_load;
  logic in_is_store;
  logic in_is_link;
  logic f3_legal;
  logic misalign;
  logic mem_bad;
  logic timeout;

  load_formatter u_fmt (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (fmt_data)
  );

  always_comb begin
    in_is_load  = (in_opcode == OPC_LOAD);
    in_is_store = (in_opcode == OPC_STORE);
    in_is_link  = (in_opcode == OPC_JAL) || (in_opcode == OPC_JALR);
    accept      = in_valid && in_ready;

    if (in_is_store)
      f3_legal = (in_funct3 == F3_B) || (in_funct3 == F3_H) || (in_funct3 == F3_W);
    else
      f3_legal = (in_funct3 == F3_B) || (in_funct3 == F3_H) || (in_funct3 == F3_W) ||
                 (in_funct3 == F3_BU) || (in_funct3 == F3_HU);

    misalign = ((in_funct3[1:0] == 2'b01) && in_alu_out[0]) ||
               ((in_funct3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00));
    mem_bad  = (in_is_load || in_is_store) && (!f3_legal || misalign);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (in_opcode)
            OPC_LOAD, OPC_STORE:
              state_next = mem_bad ? ST_IDLE : ST_REQ;
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM:
              state_next = ST_WB;
            OPC_BRANCH:
              state_next = ST_IDLE;
            default:
              state_next = ST_IDLE;
          endcase
        end
      end
      // A response coincident with the grant is not a response; only RESP samples rvalid.
      ST_REQ: begin
        if (mem_gnt) begin
          state_next = is_load_q ? ST_RESP : ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_next = ST_WB;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end
      end
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= (accept && mem_bad) || timeout;
      if (state_next != state)
        cnt <= '0;
      else if ((state == ST_REQ) || (state == ST_RESP))
        cnt <= cnt + 1'b1;
    end
  end

  // wb_q holds the link/ALU value from accept, later overwritten by load data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      rs2_q     <= '0;
      wb_q      <= '0;
    end else begin
      if (accept) begin
        is_load_q <= in_is_load;
        funct3_q  <= in_funct3;
        rd_q      <= in_rd;
        addr_q    <= in_alu_out;
        rs2_q     <= in_rs2_data;
        wb_q      <= in_is_link ? (in_pc + 32'd4) : in_alu_out;
      end else if ((state == ST_RESP) && mem_rvalid) begin
        wb_q <= fmt_data;
      end
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && ready_q;
    mem_req   = (state == ST_REQ);
    mem_we    = mem_req && !is_load_q;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (mem_we) begin
      case (funct3_q[1:0])
        2'b00: begin
          mem_wstrb = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{rs2_q[7:0]}};
        end
        2'b01: begin
          mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{rs2_q[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = rs2_q;
        end
      endcase
    end
    wb_en   = (state == ST_WB) && (rd_q != 5'd0);
    wb_rd   = rd_q;
    wb_data = wb_q;
    lsu_err = err_q;
  end

endmodule
